// File: rtl/pipe_adder_pkg.sv
// Shared defaults and derived constants for the segmented pipelined adder.
package pipe_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SEG   = 8;

  function automatic int calcNseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/add_slice.sv
// One SEG-bit ripple segment: sum, carry out, and the carry flowing into its MSB
// (the latter is what the final stage needs for signed overflow).
module add_slice
  import pipe_adder_pkg::*;
#(
  parameter int SEG = DEFAULT_SEG
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           ci_i,
  output logic [SEG-1:0] s_o,
  output logic           co_o,
  output logic           cmsb_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, ci_i};

  // Carry into the MSB is recovered from the MSB's own sum bit and operands.
  assign cmsb_o = a_i[SEG-1] ^ b_i[SEG-1] ^ s_o[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// Carry-segmented pipelined adder/subtractor: one SEG-bit segment per stage,
// with valid/ready flow control where every stage advances together.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = calcNseg(WIDTH, SEG);

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : gBadParams
    $error("pipe_adder: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic                       adv;
  logic [NSEG-1:0]            valid_q, valid_d;
  logic [NSEG-1:0]            carry_q, carry_d;
  logic [NSEG-1:0]            cmsbVec;
  logic [NSEG-1:0][WIDTH-1:0] opA_q, opA_d;
  logic [NSEG-1:0][WIDTH-1:0] opB_q, opB_d;
  logic [NSEG-1:0][WIDTH-1:0] sum_q, sum_d;
  logic                       ovf_q, ovf_d;
  logic                       unusedBits;

  assign adv = !valid_q[NSEG-1] | out_ready;

  // Stage k adds segment k; operands travel whole so later segments stay aligned.
  for (genvar k = 0; k < NSEG; k++) begin : gStage
    logic [WIDTH-1:0] stA, stB, stS, mergedS;
    logic             stC, stV;
    logic [SEG-1:0]   segS;
    logic             segCo, segCmsb;

    if (k == 0) begin : gFirst
      assign stA = a;
      assign stB = sub ? ~b : b;
      assign stC = sub | cin;
      assign stS = '0;
      assign stV = in_valid;
    end else begin : gNext
      assign stA = opA_q[k-1];
      assign stB = opB_q[k-1];
      assign stC = carry_q[k-1];
      assign stS = sum_q[k-1];
      assign stV = valid_q[k-1];
    end

    add_slice #(.SEG(SEG)) uSlice (
      .a_i    (stA[k*SEG +: SEG]),
      .b_i    (stB[k*SEG +: SEG]),
      .ci_i   (stC),
      .s_o    (segS),
      .co_o   (segCo),
      .cmsb_o (segCmsb)
    );

    always_comb begin
      mergedS                = stS;
      mergedS[k*SEG +: SEG]  = segS;
    end

    assign opA_d[k]   = stA;
    assign opB_d[k]   = stB;
    assign sum_d[k]   = mergedS;
    assign carry_d[k] = segCo;
    assign valid_d[k] = stV;
    assign cmsbVec[k] = segCmsb;
  end

  assign ovf_d = cmsbVec[NSEG-1] ^ carry_d[NSEG-1];

  // The last stage's operand copies and the lower segments' MSB carries have no consumer.
  assign unusedBits = ^{opA_q[NSEG-1], opB_q[NSEG-1], cmsbVec};

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q[NSEG-1];
  assign sum       = sum_q[NSEG-1];
  assign cout      = carry_q[NSEG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench driving a 16/8 and a 32/8 pipe_adder from the same stimulus;
// index 0 of the per-DUT arrays is the 16-bit instance, index 1 the 32-bit one.
module tb_pipe_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        latChk;
    int          accCycle;
  } expItem_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        outReady = 1'b1;
  logic [31:0] aIn = '0;
  logic [31:0] bIn = '0;

  logic        inReady16, outValid16, cout16, ovf16;
  logic [15:0] sum16;
  logic        inReady32, outValid32, cout32, ovf32;
  logic [31:0] sum32;

  int       checks = 0;
  int       failures = 0;
  int       cycle = 0;
  expItem_t expQ[2][$];
  logic     prevStall[2] = '{1'b0, 1'b0};
  int       latency[2] = '{2, 4};

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  pipe_adder #(.WIDTH(16), .SEG(8)) uDut16 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady16),
    .a(aIn[15:0]), .b(bIn[15:0]), .cin(cin), .sub(sub),
    .out_valid(outValid16), .out_ready(outReady),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  pipe_adder #(.WIDTH(32), .SEG(8)) uDut32 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady32),
    .a(aIn), .b(bIn), .cin(cin), .sub(sub),
    .out_valid(outValid32), .out_ready(outReady),
    .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Independent arithmetic reference: returns {ovf, cout, sum} for a w-bit adder.
  function automatic logic [33:0] refModel(input int w, input logic [31:0] aV, input logic [31:0] bV,
                                           input logic cinV, input logic subV);
    logic [63:0] mask, aa, bb, full;
    logic [31:0] s;
    logic        ci, ov;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, aV} & mask;
    bb   = (subV ? ~{32'd0, bV} : {32'd0, bV}) & mask;
    ci   = subV ? 1'b1 : cinV;
    full = aa + bb + 64'(ci);
    s    = full[31:0] & mask[31:0];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, full[w], s};
  endfunction

  // Holds one operand set on the inputs until accepted, then queues expectations.
  task automatic applyStimulus(input logic [31:0] aV, input logic [31:0] bV, input logic cinV,
                               input logic subV, input logic useHand, input logic [15:0] hSum,
                               input logic hCout, input logic hOvf, input logic latChk);
    expItem_t    e;
    logic [33:0] r;
    int          waitCnt = 0;
    aIn = aV; bIn = bV; cin = cinV; sub = subV; inValid = 1'b1;
    @(negedge clk);
    while (!inReady16 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!inReady16) begin
      checkOutput("accept timeout w16", 32'(inReady16), 32'd1);
    end else begin
      r = refModel(16, aV, bV, cinV, subV);
      e.sum      = useHand ? {16'd0, hSum} : r[31:0];
      e.cout     = useHand ? hCout : r[32];
      e.ovf      = useHand ? hOvf : r[33];
      e.latChk   = latChk;
      e.accCycle = cycle;
      expQ[0].push_back(e);
      if (inReady32) begin
        r = refModel(32, aV, bV, cinV, subV);
        e.sum  = r[31:0];
        e.cout = r[32];
        e.ovf  = r[33];
        expQ[1].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic monitorStep(input int d, input logic ov, input logic ir, input logic [31:0] s,
                             input logic co, input logic ovfl);
    expItem_t e;
    string    tag;
    tag = (d == 0) ? "w16" : "w32";
    if (rst) begin
      prevStall[d] = 1'b0;
      return;
    end
    if (prevStall[d]) checkOutput({tag, " out_valid held"}, 32'(ov), 32'd1);
    if (ov) begin
      if (expQ[d].size() == 0) begin
        checkOutput({tag, " unexpected result"}, 32'(ov), 32'd0);
      end else begin
        e = expQ[d][0];
        checkOutput({tag, " sum"}, s, e.sum);
        checkOutput({tag, " cout"}, 32'(co), 32'(e.cout));
        checkOutput({tag, " ovf"}, 32'(ovfl), 32'(e.ovf));
        if (!outReady) begin
          checkOutput({tag, " in_ready during stall"}, 32'(ir), 32'd0);
        end else begin
          if (e.latChk) checkOutput({tag, " latency"}, 32'(cycle - e.accCycle), 32'(latency[d]));
          void'(expQ[d].pop_front());
        end
      end
    end
    prevStall[d] = ov && !outReady;
  endtask

  always @(negedge clk) begin
    monitorStep(0, outValid16, inReady16, {16'd0, sum16}, cout16, ovf16);
    monitorStep(1, outValid32, inReady32, sum32, cout32, ovf32);
  end

  task automatic waitDrain();
    int n = 0;
    while ((expQ[0].size() != 0 || expQ[1].size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain w16", 32'(expQ[0].size()), 32'd0);
    checkOutput("drain w32", 32'(expQ[1].size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Power-on reset and the idle state that must follow it.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset out_valid w16", 32'(outValid16), 32'd0);
    checkOutput("reset sum w16", {16'd0, sum16}, 32'd0);
    checkOutput("reset cout w16", 32'(cout16), 32'd0);
    checkOutput("reset ovf w16", 32'(ovf16), 32'd0);
    checkOutput("reset in_ready w16", 32'(inReady16), 32'd1);
    checkOutput("reset out_valid w32", 32'(outValid32), 32'd0);
    checkOutput("reset sum w32", sum32, 32'd0);
    checkOutput("reset in_ready w32", 32'(inReady32), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors; 16-bit expectations hand-computed, 32-bit from the model.
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
    applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    waitDrain();

    // Back-to-back random stream with a three-cycle downstream stall in the middle.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [31:0] ra, rb;
          logic        rc, rs;
          ra = $urandom;
          rb = $urandom;
          rc = 1'($urandom);
          rs = 1'($urandom);
          applyStimulus(ra, rb, rc, rs, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 outReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 outReady = 1'b1;
      end
    join
    waitDrain();

    // Reset with two operations in flight plus a simultaneous input transfer.
    outReady = 1'b0;
    applyStimulus(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    aIn = 32'h0000_5555; bIn = 32'h0000_6666; inValid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    inValid = 1'b0;
    expQ[0].delete();
    expQ[1].delete();
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("post-rst out_valid w16", 32'(outValid16), 32'd0);
    checkOutput("post-rst sum w16", {16'd0, sum16}, 32'd0);
    checkOutput("post-rst in_ready w16", 32'(inReady16), 32'd1);
    checkOutput("post-rst out_valid w32", 32'(outValid32), 32'd0);
    checkOutput("post-rst in_ready w32", 32'(inReady32), 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;

    applyStimulus(32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 1'b1);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL provide parameter SEG, default 8, carry-segment width; WIDTH SHALL be an integer multiple of SEG, and elaboration SHALL fail otherwise.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port in_valid, input, 1, operand set present.
REQ-007 Port in_ready, output, 1, block accepts an operand set this cycle.
REQ-008 Port a, input, WIDTH, operand A.
REQ-009 Port b, input, WIDTH, operand B.
REQ-010 Port cin, input, 1, carry-in; ignored when sub=1.
REQ-011 Port sub, input, 1, 0 = A+B+cin, 1 = A-B.
REQ-012 Port out_valid, output, 1, result present.
REQ-013 Port out_ready, input, 1, downstream accepts the result.
REQ-014 Port sum, output, WIDTH, result modulo 2^WIDTH.
REQ-015 Port cout, output, 1, carry out of the MSB; in subtract mode 1 = no borrow.
REQ-016 Port ovf, output, 1, two's-complement signed overflow.

Function
REQ-017 NSEG = WIDTH/SEG pipeline stages; stage k adds bits [k*SEG +: SEG] using the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-018 Subtract: B operand = ~b and effective carry-in = 1; add: B operand = b and effective carry-in = cin.
REQ-019 Operands of not-yet-added segments SHALL be delayed alongside, so sum bits of all segments emerge aligned in the same cycle.
REQ-020 Transfer on in_valid & in_ready; result transfer on out_valid & out_ready.
REQ-021 Advance enable adv = !out_valid | out_ready; in_ready = adv; all stages and valid bits shift only when adv = 1.
REQ-022 Latency: an accepted operand set SHALL present out_valid exactly NSEG cycles later when adv stays 1; each cycle adv = 0 adds one cycle.
REQ-023 Throughput: one result per cycle while out_ready = 1.
REQ-024 Bubbles (in_valid = 0 while adv = 1) SHALL propagate as valid = 0 slots; no bubble collapsing.
REQ-025 While out_valid = 1 and out_ready = 0, sum/cout/ovf SHALL hold stable.
REQ-026 ovf = carry into MSB XOR carry out of MSB, evaluated in the final stage.
REQ-027 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-028 On rst = 1 at a clock edge all valid bits, out_valid, sum, cout and ovf SHALL become 0; in-flight operations SHALL be discarded.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 rst SHALL take priority over any simultaneous transfer.

Structure
REQ-031 A shared package SHALL hold default WIDTH/SEG constants and the derived NSEG function.
REQ-032 One sub-module, add_slice, SHALL implement a SEG-bit ripple segment (a, b, ci -> s, co, carry-into-MSB); pipe_adder SHALL instantiate NSEG copies.

Verification (WIDTH=16, SEG=8)
REQ-033 a=0x00FF, b=0x0001, cin=0, sub=0 -> sum=0x0100, cout=0, ovf=0, out_valid exactly 2 cycles after acceptance.
REQ-034 a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0; a=0x0005, b=0x0003, sub=1 -> sum=0x0002, cout=1.
REQ-035 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0; a=0xFFFF, b=0x0001, cin=1 -> sum=0x0001, cout=1, ovf=0.
REQ-036 Back-to-back stream of 10 random sets with out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during hold, outputs stable, all 10 results correct and in order.
REQ-037 rst asserted for one cycle with 2 operations in flight -> out_valid=0 next cycle, no stale result ever emerges, in_ready=1 the cycle after rst deasserts.
REQ-038 Regression SHALL repeat REQ-033 to REQ-037 with WIDTH=32, SEG=8 (latency 4) against a reference model.
